// File: rtl/demux_frame_ctrl.sv
// demux_frame_ctrl: serial frame front-end for a 1-to-4 demux.
// Frame format: start bit (1), address MSB, address LSB, PAYLOAD_LEN payload bits.
// The address is held on s1/s0 and each payload bit is shown on `a` for one cycle.
// Optional build macro DEMUX_FRAME_PARITY_EN adds a trailing even-parity bit
// covering the address and payload bits, checked into the `err` pulse.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a start bit; valid zeros are idle line
// ST_ADDR_HI | next valid bit is the address MSB (kept in a shadow reg)
// ST_ADDR_LO | next valid bit is the address LSB; s1/s0 load together
// ST_PAYLOAD | forwarding payload bits to `a`, counting up to PAYLOAD_LEN
// ST_PARITY  | (parity build) waiting for the parity bit
module demux_frame_ctrl #(
  parameter int PAYLOAD_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic din_valid,
  input  logic abort,
  output logic a,
  output logic s1,
  output logic s0,
  output logic busy,
  output logic frame_done,
  output logic err
);

`ifdef DEMUX_FRAME_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR_HI, ST_ADDR_LO, ST_PAYLOAD, ST_PARITY
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR_HI, ST_ADDR_LO, ST_PAYLOAD
  } state_e;
`endif

  // Counter is 8 bits; legal lengths 1..255 never wrap inside a frame.
  localparam logic [7:0] LEN = 8'(PAYLOAD_LEN);

  state_e     state_q, state_d;
  logic       addr_hi_q, addr_hi_d;
  logic       s1_q, s1_d;
  logic       s0_q, s0_d;
  logic       a_q, a_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;

`ifdef DEMUX_FRAME_PARITY_EN
  logic       par_q, par_d;
  logic       err_q, err_d;
`endif

  assign cnt_inc = cnt_q + 8'd1;

  // Next-state and next-output decode; abort overrides any bit in its cycle.
  always_comb begin
    state_d   = state_q;
    addr_hi_d = addr_hi_q;
    s1_d      = s1_q;
    s0_d      = s0_q;
    cnt_d     = cnt_q;
    a_d       = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef DEMUX_FRAME_PARITY_EN
    par_d     = par_q;
    err_d     = 1'b0;
`endif
    if (abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else if (din_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (din) begin
            state_d = ST_ADDR_HI;
            busy_d  = 1'b1;
          end
        end
        ST_ADDR_HI: begin
          addr_hi_d = din;
`ifdef DEMUX_FRAME_PARITY_EN
          par_d     = din;
`endif
          state_d   = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          s1_d    = addr_hi_q;
          s0_d    = din;
          cnt_d   = 8'd0;
`ifdef DEMUX_FRAME_PARITY_EN
          par_d   = par_q ^ din;
`endif
          state_d = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          a_d   = din;
          cnt_d = cnt_inc;
`ifdef DEMUX_FRAME_PARITY_EN
          par_d = par_q ^ din;
          if (cnt_inc == LEN) begin
            state_d = ST_PARITY;
          end
`else
          if (cnt_inc == LEN) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
`endif
        end
`ifdef DEMUX_FRAME_PARITY_EN
        ST_PARITY: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = (din != par_q);
        end
`endif
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset clears everything, including s1/s0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_hi_q <= 1'b0;
      s1_q      <= 1'b0;
      s0_q      <= 1'b0;
      cnt_q     <= 8'd0;
      a_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_hi_q <= addr_hi_d;
      s1_q      <= s1_d;
      s0_q      <= s0_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef DEMUX_FRAME_PARITY_EN
  // Running parity and mismatch flag for the parity build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      par_q <= par_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign a          = a_q;
  assign s1         = s1_q;
  assign s0         = s0_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_demux_frame_ctrl.sv
// Self-checking bench for demux_frame_ctrl (PAYLOAD_LEN = 8).
module tb_demux_frame_ctrl;

  localparam int LEN = 8;
`ifdef DEMUX_FRAME_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic din, din_valid, abort;
  logic a, s1, s0, busy, frame_done, err;

  int n_pass = 0;
  int n_total = 0;
  logic es1 = 1'b0;
  logic es0 = 1'b0;

  demux_frame_ctrl #(.PAYLOAD_LEN(LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .abort      (abort),
    .a          (a),
    .s1         (s1),
    .s0         (s0),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic d, v, ab;
    logic ea, es1, es0, eb, ed;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic d, v, ab, ea, xs1, xs0, eb, ed);
    vec_t t;
    t.d = d; t.v = v; t.ab = ab;
    t.ea = ea; t.es1 = xs1; t.es0 = xs0; t.eb = eb; t.ed = ed;
    vecs.push_back(t);
  endfunction

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic d, input logic v, input logic ab);
    din = d; din_valid = v; abort = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic chk_all(input string tag, input logic ea, xs1, xs0, eb, ed, ee);
    chk({tag, ".a"}, a, ea);
    chk({tag, ".s1"}, s1, xs1);
    chk({tag, ".s0"}, s0, xs0);
    chk({tag, ".busy"}, busy, eb);
    chk({tag, ".frame_done"}, frame_done, ed);
    chk({tag, ".err"}, err, ee);
  endtask

  // Random frame with random gaps, idle zeros and occasional abort; expectations
  // come from the frame's bit positions, not from any controller state.
  task automatic rand_frame();
    logic [1:0] ad;
    logic [7:0] pl;
    logic pexp, bitv, last, ea, ee;
    int nb, abort_at;
    nb = 3 + LEN + PAR;
    ad = 2'($urandom_range(0, 3));
    pl = 8'($urandom);
    pexp = ad[1] ^ ad[0] ^ (^pl);
    abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
    repeat ($urandom_range(0, 2)) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      chk_all("rnd_idle", 1'b0, es1, es0, 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < nb; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        chk_all("rnd_gap", 1'b0, es1, es0, k > 0, 1'b0, 1'b0);
      end
      if (k == abort_at) begin
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        chk_all("rnd_abort", 1'b0, es1, es0, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (k == 0)            bitv = 1'b1;
      else if (k == 1)       bitv = ad[1];
      else if (k == 2)       bitv = ad[0];
      else if (k < 3 + LEN)  bitv = pl[LEN - 1 - (k - 3)];
      else                   bitv = 1'($urandom_range(0, 1));
      cyc(bitv, 1'b1, 1'b0);
      if (k == 2) begin
        es1 = ad[1];
        es0 = ad[0];
      end
      last = (k == nb - 1);
      ea = (k >= 3 && k < 3 + LEN) ? bitv : 1'b0;
      ee = (PAR == 1 && last) ? (bitv != pexp) : 1'b0;
      chk_all("rnd", ea, es1, es0, !last, last, ee);
    end
  endtask

  initial begin
    logic [7:0] p1, p2, pa, pb;
    logic b, lst;
    logic bits[22];
    int ndone;

    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

`ifndef DEMUX_FRAME_PARITY_EN
    p1 = 8'b1011_0010;
    p2 = 8'b0101_0101;
    // A: address 10, continuous valid
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      b = p1[7 - i]; lst = (i == 7);
      add(b, 1, 0, b, 1, 0, !lst, lst);
    end
    add(0, 0, 0, 0, 1, 0, 0, 0);
    // B: same frame, valid low on alternate cycles (din=1 on gaps must be ignored)
    add(1, 1, 0, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0);
    add(0, 1, 0, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      b = p1[7 - i]; lst = (i == 7);
      add(b, 1, 0, b, 1, 0, !lst, lst);
      add(1, 0, 0, 0, 1, 0, !lst, 0);
    end
    // C: abort after payload bit 3, start bit in abort cycle discarded
    add(1, 1, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 1, 0);
    add(0, 1, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 1, 1, 0, 1, 0);
    add(0, 1, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 1, 1, 0, 1, 0);
    add(1, 1, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0);
    // then a frame to address 01
    add(1, 1, 0, 0, 1, 0, 1, 0);
    add(0, 1, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      b = p2[7 - i]; lst = (i == 7);
      add(b, 1, 0, b, 0, 1, !lst, lst);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].d, vecs[i].v, vecs[i].ab);
      chk_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].es1, vecs[i].es0,
              vecs[i].eb, vecs[i].ed, 1'b0);
    end

    // Back-to-back frames: address 11 then 00, no gap.
    pa = 8'hA5; pb = 8'h3C;
    bits[0] = 1'b1; bits[1] = 1'b1; bits[2] = 1'b1;
    bits[11] = 1'b1; bits[12] = 1'b0; bits[13] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bits[3 + i]  = pa[7 - i];
      bits[14 + i] = pb[7 - i];
    end
    ndone = 0;
    for (int k = 0; k < 22; k++) begin
      cyc(bits[k], 1'b1, 1'b0);
      if (frame_done === 1'b1) ndone++;
      if (k == 2)  begin chk("b2b.s1_first", s1, 1'b1); chk("b2b.s0_first", s0, 1'b1); end
      if (k == 12) begin chk("b2b.s1_hold", s1, 1'b1); chk("b2b.s0_hold", s0, 1'b1); end
      if (k == 13) begin chk("b2b.s1_new", s1, 1'b0); chk("b2b.s0_new", s0, 1'b0); end
      if (k == 10) chk("b2b.done1", frame_done, 1'b1);
      if (k == 11) chk("b2b.busy_restart", busy, 1'b1);
      if (k == 21) chk("b2b.done2", frame_done, 1'b1);
    end
    n_total++;
    if (ndone != 2) $display("FAIL b2b.done_count: got %0d expected 2", ndone);
    else n_pass++;
`else
    // Parity build: address 01, payload 00000001, correct parity is 0.
    for (int pbit = 0; pbit < 2; pbit++) begin
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("par.s1", s1, 1'b0);
      chk("par.s0", s0, 1'b1);
      for (int i = 0; i < 8; i++) cyc(i == 7, 1'b1, 1'b0);
      chk_all("par.last_payload", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'(pbit), 1'b1, 1'b0);
      chk_all("par.end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'(pbit));
      cyc(1'b0, 1'b0, 1'b0);
      chk_all("par.after", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
`endif

    // Reset in the middle of the payload clears outputs without waiting for a clock.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk_all("pre_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk_all("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    es1 = 1'b0; es0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk_all("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    for (int f = 0; f < 150; f++) rand_frame();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
